// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the npc single-issue RV32I core.
//   - XLEN / register-address widths
//   - RV32I opcode and funct3 constants
//   - FSM state enum (fetch / execute)
//   - ALU operation enum and the funct3/funct7 -> ALU-op decode helper
package npc_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store size funct3 (passed straight to memory as the access op)
  localparam logic [2:0] F3_MEM_B  = 3'b000;
  localparam logic [2:0] F3_MEM_H  = 3'b001;
  localparam logic [2:0] F3_MEM_W  = 3'b010;
  localparam logic [2:0] F3_MEM_BU = 3'b100;
  localparam logic [2:0] F3_MEM_HU = 3'b101;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // alt is instruction bit 30. It selects SUB only for register-register
  // ops: on ADDI that bit belongs to the immediate. For shifts it selects
  // arithmetic right shift in both forms.
  function automatic alu_op_e alu_op_decode(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_reg);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/npc_regfile.sv
// npc_regfile: 32 x 32-bit integer register file.
//   clock, reset      : clock and asynchronous active-low reset (clears all GPRs)
//   raddr1/rdata1     : read port 1 (combinational, x0 reads as zero)
//   raddr2/rdata2     : read port 2 (combinational, x0 reads as zero)
//   wen/waddr/wdata   : write port, committed on the rising clock edge;
//                       writes to x0 are dropped
//   gpr_10            : live value of a0 (x10) for trap reporting
module npc_regfile
  import npc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2,
  input  logic              wen,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   gpr_10
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 is forced on the read side as well, so it stays zero whatever the array holds.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
  assign gpr_10 = regs[10];

endmodule

// File: rtl/npc_core.sv
// npc_core: multi-cycle RV32I core, one instruction every two cycles.
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   io_Imem_raddr         : current PC, used as the fetch address
//   io_Imem_rdata_ready   : high in FETCH, core accepts an instruction
//   io_Imem_rdata_valid   : instruction word on io_Imem_rdata_bits is valid
//   io_Imem_rdata_bits    : instruction word
//   io_Dmem_wraddr        : load/store address rs1 + imm (meaningful in EXEC)
//   io_Dmem_rdata         : load data, already sized/extended by memory
//   io_Dmem_wdata         : store data (rs2)
//   io_Dmem_wop           : access size/sign, the instruction funct3
//   io_Dmem_wen           : store strobe, memory writes on the closing edge
//   io_inst_comp          : high for the single EXEC cycle of each instruction
// FETCH latches the instruction into IR. EXEC decodes IR. At the edge that
// ends EXEC, the core writes rd, updates the PC and issues the store.
// EBREAK, ECALL, FENCE and unknown opcodes fall through as PC+4 no-ops.
module npc_core
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_Imem_raddr,
  output logic        io_Imem_rdata_ready,
  input  logic        io_Imem_rdata_valid,
  input  logic [31:0] io_Imem_rdata_bits,
  output logic [31:0] io_Dmem_wraddr,
  input  logic [31:0] io_Dmem_rdata,
  output logic [31:0] io_Dmem_wdata,
  output logic [2:0]  io_Dmem_wop,
  output logic        io_Dmem_wen,
  output logic        io_inst_comp
);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] ir;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        alt;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign alt    = ir[30];

  // Immediates, all sign-extended to 32 bits
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic is_op;
  logic is_opimm;
  logic is_store;
  logic exec;

  assign is_op    = (opcode == OPC_OP);
  assign is_opimm = (opcode == OPC_OPIMM);
  assign is_store = (opcode == OPC_STORE);
  assign exec     = (state == ST_EXEC);

  // Register file
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        rf_wen;
  logic [31:0] wb_data;
  // a0 is read through hierarchy by the environment; the core itself never consumes it.
  logic [31:0] gpr_10_unused;

  npc_regfile u_rf (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (rs1),
    .rdata1 (rs1_val),
    .raddr2 (rs2),
    .rdata2 (rs2_val),
    .wen    (rf_wen),
    .waddr  (rd),
    .wdata  (wb_data),
    .gpr_10 (gpr_10_unused)
  );

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = rs1_val;
  assign rs2_s = rs2_val;

  // ALU. The second operand is rs2 for OP and the sign-extended I-immediate
  // for OP-IMM, so SLTIU compares against the extended immediate unsigned.
  alu_op_e            alu_op;
  logic signed [31:0] alu_a_s;
  logic signed [31:0] alu_b_s;
  logic [4:0]         shamt;
  logic [31:0]        alu_res;

  assign alu_op  = alu_op_decode(funct3, alt, is_op);
  assign alu_a_s = rs1_s;
  assign alu_b_s = is_op ? rs2_s : $signed(imm_i);
  assign shamt   = alu_b_s[4:0];

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      ALU_ADD:  alu_res = alu_a_s + alu_b_s;
      ALU_SUB:  alu_res = alu_a_s - alu_b_s;
      ALU_SLL:  alu_res = $unsigned(alu_a_s) << shamt;
      ALU_SLT:  alu_res = {31'd0, (alu_a_s < alu_b_s)};
      ALU_SLTU: alu_res = {31'd0, ($unsigned(alu_a_s) < $unsigned(alu_b_s))};
      ALU_XOR:  alu_res = alu_a_s ^ alu_b_s;
      ALU_SRL:  alu_res = $unsigned(alu_a_s) >> shamt;
      ALU_SRA:  alu_res = alu_a_s >>> shamt;
      ALU_OR:   alu_res = alu_a_s | alu_b_s;
      ALU_AND:  alu_res = alu_a_s & alu_b_s;
      default:  alu_res = '0;
    endcase
  end

  // Branch compare
  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = (rs1_s < rs2_s);
      F3_BGE:  br_taken = !(rs1_s < rs2_s);
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = !(rs1_val < rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Next PC, all arithmetic wraps modulo 2^32; misaligned targets are accepted.
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    case (opcode)
      OPC_JAL:    pc_next = pc + imm_j;
      OPC_JALR:   pc_next = (rs1_val + imm_i) & ~32'd1;
      OPC_BRANCH: pc_next = br_taken ? (pc + imm_b) : pc_plus4;
      default:    pc_next = pc_plus4;
    endcase
  end

  // Write-back
  logic wb_op;

  always_comb begin
    wb_op   = 1'b0;
    wb_data = '0;
    case (opcode)
      OPC_LUI:   begin wb_op = 1'b1; wb_data = imm_u;         end
      OPC_AUIPC: begin wb_op = 1'b1; wb_data = pc + imm_u;    end
      OPC_JAL:   begin wb_op = 1'b1; wb_data = pc_plus4;      end
      OPC_JALR:  begin wb_op = 1'b1; wb_data = pc_plus4;      end
      OPC_LOAD:  begin wb_op = 1'b1; wb_data = io_Dmem_rdata; end
      OPC_OPIMM: begin wb_op = 1'b1; wb_data = alu_res;       end
      OPC_OP:    begin wb_op = 1'b1; wb_data = alu_res;       end
      default:   begin wb_op = 1'b0; wb_data = '0;            end
    endcase
  end

  assign rf_wen = exec && wb_op && (is_op || is_opimm || !is_store);

  // Data memory interface
  assign io_Dmem_wraddr = rs1_val + (is_store ? imm_s : imm_i);
  assign io_Dmem_wdata  = rs2_val;
  assign io_Dmem_wop    = funct3;
  assign io_Dmem_wen    = exec && is_store;

  // Handshake outputs come straight from the state register.
  assign io_Imem_raddr       = pc;
  assign io_Imem_rdata_ready = (state == ST_FETCH);
  assign io_inst_comp        = exec;

  // FSM: FETCH -> EXEC on valid, EXEC -> FETCH unconditionally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (io_Imem_rdata_valid) begin
            ir    <= io_Imem_rdata_bits;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc    <= pc_next;
          state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_core.sv
module tb_npc_core;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;

  logic        clock;
  logic        reset;
  logic [31:0] io_Imem_raddr;
  logic        io_Imem_rdata_ready;
  logic        io_Imem_rdata_valid;
  logic [31:0] io_Imem_rdata_bits;
  logic [31:0] io_Dmem_wraddr;
  logic [31:0] io_Dmem_rdata;
  logic [31:0] io_Dmem_wdata;
  logic [2:0]  io_Dmem_wop;
  logic        io_Dmem_wen;
  logic        io_inst_comp;

  npc_core #(.RESET_PC(RESET_PC)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_Imem_raddr       (io_Imem_raddr),
    .io_Imem_rdata_ready (io_Imem_rdata_ready),
    .io_Imem_rdata_valid (io_Imem_rdata_valid),
    .io_Imem_rdata_bits  (io_Imem_rdata_bits),
    .io_Dmem_wraddr      (io_Dmem_wraddr),
    .io_Dmem_rdata       (io_Dmem_rdata),
    .io_Dmem_wdata       (io_Dmem_wdata),
    .io_Dmem_wop         (io_Dmem_wop),
    .io_Dmem_wen         (io_Dmem_wen),
    .io_inst_comp        (io_inst_comp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        is_store;
    logic        chk_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  wop;
  } exp_t;

  exp_t sb_q[$];

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1[4:0], f3, rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], T_OP};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2[4:0], rs1[4:0], f3, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'b1101111};
  endfunction

  // Issue one instruction at a FETCH negedge, push its expectation, then pop
  // and compare when the DUT signals retirement.
  task automatic run_inst(input string name, input logic [31:0] inst, input logic [31:0] next_pc,
                          input logic is_store, input logic chk_mem, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] wop, input logic [31:0] rdata);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    e.pc       = model_pc;
    e.next_pc  = next_pc;
    e.is_store = is_store;
    e.chk_mem  = chk_mem;
    e.addr     = addr;
    e.wdata    = wdata;
    e.wop      = wop;
    sb_q.push_back(e);
    io_Imem_rdata_bits  = inst;
    io_Imem_rdata_valid = 1'b1;
    io_Dmem_rdata       = rdata;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 4) begin
      @(negedge clock);
      io_Imem_rdata_valid = 1'b0;
      lat++;
      if (io_inst_comp === 1'b1) seen = 1;
    end
    got = sb_q.pop_front();
    checks++;
    if (!seen || lat != 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (retired=%0b) want 1", name, lat, seen);
    end
    if (seen) begin
      checks++;
      if (io_Imem_raddr !== got.pc) begin
        errors++;
        $display("FAIL %s exec_pc: got %h want %h", name, io_Imem_raddr, got.pc);
      end
      checks++;
      if (io_Dmem_wen !== got.is_store) begin
        errors++;
        $display("FAIL %s wen: got %b want %b", name, io_Dmem_wen, got.is_store);
      end
      if (got.chk_mem) begin
        checks++;
        if (io_Dmem_wraddr !== got.addr) begin
          errors++;
          $display("FAIL %s addr: got %h want %h", name, io_Dmem_wraddr, got.addr);
        end
        checks++;
        if (io_Dmem_wop !== got.wop) begin
          errors++;
          $display("FAIL %s wop: got %b want %b", name, io_Dmem_wop, got.wop);
        end
        if (got.is_store) begin
          checks++;
          if (io_Dmem_wdata !== got.wdata) begin
            errors++;
            $display("FAIL %s wdata: got %h want %h", name, io_Dmem_wdata, got.wdata);
          end
        end
      end
      @(negedge clock);
      checks++;
      if (io_Imem_raddr !== got.next_pc) begin
        errors++;
        $display("FAIL %s next_pc: got %h want %h", name, io_Imem_raddr, got.next_pc);
      end
      checks++;
      if (io_inst_comp !== 1'b0 || io_Imem_rdata_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s back_to_fetch: got comp=%b ready=%b want comp=0 ready=1",
                 name, io_inst_comp, io_Imem_rdata_ready);
      end
    end
    model_pc = got.next_pc;
  endtask

  task automatic plain(input string name, input logic [31:0] inst);
    run_inst(name, inst, model_pc + 32'd4, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io_Imem_rdata_valid = 1'b0;
    io_Imem_rdata_bits  = 32'd0;
    io_Dmem_rdata       = 32'd0;
    repeat (2) @(negedge clock);
    checks++;
    if (io_Imem_rdata_ready !== 1'b1 || io_Dmem_wen !== 1'b0 || io_inst_comp !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b wen=%b comp=%b want 1 0 0",
               io_Imem_rdata_ready, io_Dmem_wen, io_inst_comp);
    end
    checks++;
    if (io_Imem_raddr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_pc: got %h want %h", io_Imem_raddr, RESET_PC);
    end
    checks++;
    if (dut.u_rf.gpr_10 !== 32'd0 || dut.u_rf.regs[1] !== 32'd0) begin
      errors++;
      $display("FAIL reset_gpr: got x10=%h x1=%h want 0", dut.u_rf.gpr_10, dut.u_rf.regs[1]);
    end
    reset = 1'b1;
    model_pc = RESET_PC;
    @(negedge clock);
  endtask

  task automatic test_addi();
    plain("addi_a0", 32'h0050_0513);
    checks++;
    if (dut.u_rf.gpr_10 !== 32'd5) begin
      errors++;
      $display("FAIL addi_a0 gpr_10: got %h want 00000005", dut.u_rf.gpr_10);
    end
    checks++;
    if (io_Imem_raddr !== 32'h8000_0004) begin
      errors++;
      $display("FAIL addi_a0 pc: got %h want 80000004", io_Imem_raddr);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (io_Imem_rdata_ready !== 1'b1 || io_inst_comp !== 1'b0 || io_Imem_raddr !== model_pc) begin
        errors++;
        $display("FAIL stall_%0d: got ready=%b comp=%b pc=%h want 1 0 %h",
                 k, io_Imem_rdata_ready, io_inst_comp, io_Imem_raddr, model_pc);
      end
    end
  endtask

  task automatic test_store();
    plain("lui_x1", enc_u(32'h80000, 1, T_LUI));
    plain("addi_x1", enc_i(256, 1, 3'b000, 1, T_OPIMM));
    plain("lui_x2", enc_u(32'hDEADC, 2, T_LUI));
    plain("addi_x2", enc_i(-273, 2, 3'b000, 2, T_OPIMM));
    checks++;
    if (dut.u_rf.regs[1] !== 32'h8000_0100 || dut.u_rf.regs[2] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_setup: got x1=%h x2=%h want 80000100 deadbeef",
               dut.u_rf.regs[1], dut.u_rf.regs[2]);
    end
    run_inst("sw", enc_s(8, 2, 1, 3'b010), model_pc + 32'd4, 1'b1, 1'b1,
             32'h8000_0108, 32'hDEAD_BEEF, 3'b010, 32'd0);
  endtask

  task automatic test_load();
    run_inst("lb", enc_i(0, 1, 3'b000, 3, T_LOAD), model_pc + 32'd4, 1'b0, 1'b1,
             32'h8000_0100, 32'd0, 3'b000, 32'hFFFF_FF80);
    checks++;
    if (dut.u_rf.regs[3] !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_x3: got %h want ffffff80", dut.u_rf.regs[3]);
    end
  endtask

  task automatic test_alu();
    int          ridx [13];
    logic [31:0] rexp [13];
    plain("addi_x4", enc_i(5, 0, 3'b000, 4, T_OPIMM));
    plain("sra", enc_r(7'b0100000, 4, 3, 3'b101, 5));
    plain("srl", enc_r(7'b0000000, 4, 3, 3'b101, 6));
    plain("slt", enc_r(7'b0000000, 4, 3, 3'b010, 7));
    plain("sltu", enc_r(7'b0000000, 4, 3, 3'b011, 8));
    plain("sltiu", enc_i(-1, 4, 3'b011, 9, T_OPIMM));
    plain("sub", enc_r(7'b0100000, 3, 4, 3'b000, 11));
    plain("addi_x12", enc_i(37, 0, 3'b000, 12, T_OPIMM));
    plain("sll", enc_r(7'b0000000, 12, 4, 3'b001, 13));
    plain("xori", enc_i(-1, 3, 3'b100, 14, T_OPIMM));
    plain("srai", enc_i(32'h404, 3, 3'b101, 20, T_OPIMM));
    plain("slti", enc_i(-127, 3, 3'b010, 22, T_OPIMM));
    plain("add_wrap", enc_r(7'b0000000, 2, 2, 3'b000, 23));
    plain("addi_x0", enc_i(7, 0, 3'b000, 0, T_OPIMM));
    plain("addi_x15", enc_i(1, 0, 3'b000, 15, T_OPIMM));
    ridx[0]  = 5;  rexp[0]  = 32'hFFFF_FFFC;
    ridx[1]  = 6;  rexp[1]  = 32'h07FF_FFFC;
    ridx[2]  = 7;  rexp[2]  = 32'd1;
    ridx[3]  = 8;  rexp[3]  = 32'd0;
    ridx[4]  = 9;  rexp[4]  = 32'd1;
    ridx[5]  = 11; rexp[5]  = 32'h0000_0085;
    ridx[6]  = 13; rexp[6]  = 32'h0000_00A0;
    ridx[7]  = 14; rexp[7]  = 32'h0000_007F;
    ridx[8]  = 20; rexp[8]  = 32'hFFFF_FFF8;
    ridx[9]  = 22; rexp[9]  = 32'd1;
    ridx[10] = 23; rexp[10] = 32'hBD5B_7DDE;
    ridx[11] = 0;  rexp[11] = 32'd0;
    ridx[12] = 15; rexp[12] = 32'd1;
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (dut.u_rf.regs[ridx[k]] !== rexp[k]) begin
        errors++;
        $display("FAIL alu_x%0d: got %h want %h", ridx[k], dut.u_rf.regs[ridx[k]], rexp[k]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] link;
    plain("addi_x16", enc_i(-240, 1, 3'b000, 16, T_OPIMM));
    run_inst("jalr_x0", enc_i(0, 16, 3'b000, 0, T_JALR), 32'h8000_0010,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    run_inst("beq_back", enc_b(-8, 0, 0, 3'b000), 32'h8000_0008,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    plain("addi_x5", enc_i(-224, 1, 3'b000, 5, T_OPIMM));
    run_inst("jalr_odd", enc_i(3, 5, 3'b000, 1, T_JALR), 32'h8000_0022,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    checks++;
    if (dut.u_rf.regs[1] !== 32'h8000_0010) begin
      errors++;
      $display("FAIL jalr_link: got %h want 80000010", dut.u_rf.regs[1]);
    end
    run_inst("bne_nt", enc_b(-8, 0, 0, 3'b001), 32'h8000_0026,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    run_inst("blt_t", enc_b(16, 4, 3, 3'b100), 32'h8000_0036,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    run_inst("bgeu_t", enc_b(16, 4, 3, 3'b111), 32'h8000_0046,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    run_inst("bge_nt", enc_b(16, 4, 3, 3'b101), 32'h8000_004A,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    run_inst("bltu_nt", enc_b(16, 4, 3, 3'b110), 32'h8000_004E,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    run_inst("jal_back", enc_j(-32, 17), 32'h8000_002E,
             1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 32'd0);
    link = 32'h8000_0052;
    checks++;
    if (dut.u_rf.regs[17] !== link) begin
      errors++;
      $display("FAIL jal_link: got %h want %h", dut.u_rf.regs[17], link);
    end
    plain("auipc", enc_u(1, 18, T_AUIPC));
    checks++;
    if (dut.u_rf.regs[18] !== 32'h8000_102E) begin
      errors++;
      $display("FAIL auipc_x18: got %h want 8000102e", dut.u_rf.regs[18]);
    end
  endtask

  task automatic test_ebreak();
    plain("ebreak", 32'h0010_0073);
    checks++;
    if (dut.u_rf.gpr_10 !== 32'd5 || dut.u_rf.regs[1] !== 32'h8000_0010) begin
      errors++;
      $display("FAIL ebreak_state: got x10=%h x1=%h want 00000005 80000010",
               dut.u_rf.gpr_10, dut.u_rf.regs[1]);
    end
  endtask

  task automatic test_reset_mid_exec();
    io_Imem_rdata_bits  = enc_s(8, 2, 1, 3'b010);
    io_Imem_rdata_valid = 1'b1;
    @(negedge clock);
    io_Imem_rdata_valid = 1'b0;
    checks++;
    if (io_inst_comp !== 1'b1 || io_Dmem_wen !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got comp=%b wen=%b want 1 1", io_inst_comp, io_Dmem_wen);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (io_Dmem_wen !== 1'b0 || io_inst_comp !== 1'b0 || io_Imem_rdata_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ctrl: got wen=%b comp=%b ready=%b want 0 0 1",
               io_Dmem_wen, io_inst_comp, io_Imem_rdata_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (io_Imem_raddr !== RESET_PC || dut.u_rf.regs[1] !== 32'd0) begin
      errors++;
      $display("FAIL abort_pc: got pc=%h x1=%h want %h 0", io_Imem_raddr, dut.u_rf.regs[1], RESET_PC);
    end
    model_pc = RESET_PC;
    plain("addi_after_reset", 32'h0050_0513);
    checks++;
    if (dut.u_rf.gpr_10 !== 32'd5) begin
      errors++;
      $display("FAIL after_reset_a0: got %h want 00000005", dut.u_rf.gpr_10);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stall();
    test_store();
    test_load();
    test_alu();
    test_branch();
    test_ebreak();
    test_reset_mid_exec();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
